wb_stage_pipelined: RTL and testbench
=====================================

Name: wb_stage_pipelined

Overview:
- Next-generation writeback stage for the 5-stage MIPS pipeline.
- Adds a registered MEM/WB capture stage with stall and flush, sub-word load extraction with sign/zero extension, and a parametrised register file with N read ports and write-through bypass.
- Sits after the memory stage. Drives the architectural register file and supplies decode-stage operand reads.

Parameters:
- NUM_READ, 2, number of independent register-file read ports.
- LINK_REG, 31, destination register index used for link writes (RegDst=2'b10).
- ZERO_REG_HARD, 1, when 1 register 0 reads as 0 and writes to it are discarded.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- stall  in  1  hold stage contents; no commit.
- flush  in  1  kill the incoming instruction.
- IR  in  32  instruction word.
- PC_plus_4  in  32  link value.
- Memory_Read_Data  in  32  raw aligned word from data memory.
- ALU_out  in  32  ALU result; bits [1:0] are also the byte offset for loads.
- RegWrite  in  1  instruction writes a register.
- RegDst  in  2  00 selects IR[20:16], 01 selects IR[15:11], 10 selects LINK_REG, 11 selects IR[20:16].
- MemtoReg  in  2  00 selects ALU, 01 selects load, 10 or 11 selects PC_plus_4.
- LoadType  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW.
- rd_addr  in  NUM_READ*5  packed read addresses; port k uses bits [5k+4:5k].
- rd_data  out  NUM_READ*32  packed read data, combinational.
- WriteBackData  out  32  data of the instruction held in the stage.
- WriteBackReg  out  5  destination register of the held instruction.
- WriteBackEn  out  1  a register write commits at the next edge.
- wb_valid  out  1  stage holds a valid instruction.
- retire_count  out  32  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, reset=0): stage valid=0, all stage fields=0, all 32 registers=0, retire_count=0. Consequently WriteBackData=0, WriteBackReg=0, WriteBackEn=0, wb_valid=0. Reset mid-operation drops any pending write.
- Stage capture at a rising edge:
  - stall=1: stage holds its contents. flush and in_valid are ignored for this edge.
  - stall=0, flush=1: stage valid<=0.
  - stall=0, flush=0: stage<=inputs and valid<=in_valid.
- flush never kills the instruction already in the stage; it is older and commits.
- Commit: WriteBackEn = valid & RegWrite_s & !stall & !(ZERO_REG_HARD & WriteBackReg==0). The register file writes WriteBackData at that edge.
- Latency: inputs presented at edge N commit at edge N+1 if stall=0 during cycle N+1.
- A held instruction under stall commits exactly once, on the first edge with stall=0.
- WriteBackData/WriteBackReg are combinational from the stage registers.
- Load extraction uses off=ALU_out_s[1:0]. Byte lane off is bits [8off+7:8off]; little-endian.
  - Halfword selects bits [31:16] if off[1]=1, else [15:0]. off[0] is ignored for halfwords.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Reads: rd_data[k] = 0 if address 0 and ZERO_REG_HARD=1. Otherwise it equals WriteBackData if WriteBackEn=1 and the address matches WriteBackReg (write-through bypass). Otherwise it is the register value.
- Simultaneous read of the same address on several ports returns identical data.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_count increments by 1 on every edge where valid=1 and stall=0, regardless of RegWrite. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Undefined: no counter logic is built; retire_count is tied to 0.

Test Plan:
- Reset, then R-type IR=0x012A4020 (rd=8), ALU_out=0x55, RegDst=01, MemtoReg=00, RegWrite=1 -> WriteBackReg=8, WriteBackData=0x55 one cycle later; rd_addr=8 bypasses 0x55 in that cycle and register 8 reads 0x55 afterwards.
- LB with Memory_Read_Data=0x11228344, ALU_out[1:0]=01 -> 0xFFFFFF83. LBU at the same offset -> 0x00000083. LH with off=10 -> 0x00001122. LHU with Memory_Read_Data=0x80000000, off=10 -> 0x00008000.
- JAL: RegDst=10, MemtoReg=10, PC_plus_4=0x00400008 -> register 31=0x00400008. A write targeting register 0 leaves register 0 reading 0.
- Assert stall for 3 cycles while holding a valid write -> WriteBackEn=0 throughout, single write on release; retire_count rises by exactly 1 when WB_RETIRE_CNT_EN is defined.
- flush=1 with in_valid=1 -> the held instruction commits and the incoming one never does (wb_valid=0 next cycle). Drive reset low mid-stall -> all outputs 0 immediately and no write occurs.

Source files
------------

// File: rtl/wb_stage_pipelined.sv
// MIPS writeback stage: registered MEM/WB capture, sub-word load extraction,
// multi-port register file with write-through bypass. Optional macro: WB_RETIRE_CNT_EN.
module wb_stage_pipelined #(
    parameter int NUM_READ      = 2,
    parameter int LINK_REG      = 31,
    parameter int ZERO_REG_HARD = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [31:0]            IR,
    input  logic [31:0]            PC_plus_4,
    input  logic [31:0]            Memory_Read_Data,
    input  logic [31:0]            ALU_out,
    input  logic                   RegWrite,
    input  logic [1:0]             RegDst,
    input  logic [1:0]             MemtoReg,
    input  logic [2:0]             LoadType,
    input  logic [NUM_READ*5-1:0]  rd_addr,
    output logic [NUM_READ*32-1:0] rd_data,
    output logic [31:0]            WriteBackData,
    output logic [4:0]             WriteBackReg,
    output logic                   WriteBackEn,
    output logic                   wb_valid,
    output logic [31:0]            retire_count
);

    localparam logic [4:0] LINK_IDX  = 5'(LINK_REG);
    localparam logic       ZERO_HARD = (ZERO_REG_HARD != 0);

    logic        valid_q, valid_d;
    logic [4:0]  rt_q, rt_d, rd_q, rd_d;
    logic [31:0] pc4_q, pc4_d, mrd_q, mrd_d, alu_q, alu_d;
    logic        regwrite_q, regwrite_d;
    logic [1:0]  regdst_q, regdst_d, memtoreg_q, memtoreg_d;
    logic [2:0]  loadtype_q, loadtype_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [4:0]  raddr;
    logic        unused_ir;

    // Only the two register-specifier fields of IR are ever consulted.
    assign unused_ir = ^{IR[31:21], IR[10:0]};

    always_comb begin
        valid_d    = valid_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        pc4_d      = pc4_q;
        mrd_d      = mrd_q;
        alu_d      = alu_q;
        regwrite_d = regwrite_q;
        regdst_d   = regdst_q;
        memtoreg_d = memtoreg_q;
        loadtype_d = loadtype_q;
        if (!stall) begin
            if (flush) begin
                valid_d = 1'b0;
            end else begin
                valid_d    = in_valid;
                rt_d       = IR[20:16];
                rd_d       = IR[15:11];
                pc4_d      = PC_plus_4;
                mrd_d      = Memory_Read_Data;
                alu_d      = ALU_out;
                regwrite_d = RegWrite;
                regdst_d   = RegDst;
                memtoreg_d = MemtoReg;
                loadtype_d = LoadType;
            end
        end
    end

    always_comb begin
        byte_sel = mrd_q[{alu_q[1:0], 3'b000} +: 8];
        half_sel = alu_q[1] ? mrd_q[31:16] : mrd_q[15:0];
        case (loadtype_q)
            3'b001:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_val = {24'd0, byte_sel};
            3'b011:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {16'd0, half_sel};
            default: load_val = mrd_q;
        endcase
        case (memtoreg_q)
            2'b00:   WriteBackData = alu_q;
            2'b01:   WriteBackData = load_val;
            default: WriteBackData = pc4_q;
        endcase
        case (regdst_q)
            2'b01:   WriteBackReg = rd_q;
            2'b10:   WriteBackReg = LINK_IDX;
            default: WriteBackReg = rt_q;
        endcase
    end

    assign WriteBackEn = valid_q & regwrite_q & ~stall & ~(ZERO_HARD & (WriteBackReg == 5'd0));
    assign wb_valid    = valid_q;

    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (WriteBackEn) begin
            regs_d[WriteBackReg] = WriteBackData;
        end
    end

    always_comb begin
        rd_data = '0;
        raddr   = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            raddr = rd_addr[5*k +: 5];
            if (ZERO_HARD && raddr == 5'd0) begin
                rd_data[32*k +: 32] = '0;
            end else if (WriteBackEn && raddr == WriteBackReg) begin
                rd_data[32*k +: 32] = WriteBackData;
            end else begin
                rd_data[32*k +: 32] = regs_q[raddr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            rt_q       <= '0;
            rd_q       <= '0;
            pc4_q      <= '0;
            mrd_q      <= '0;
            alu_q      <= '0;
            regwrite_q <= 1'b0;
            regdst_q   <= '0;
            memtoreg_q <= '0;
            loadtype_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            pc4_q      <= pc4_d;
            mrd_q      <= mrd_d;
            alu_q      <= alu_d;
            regwrite_q <= regwrite_d;
            regdst_q   <= regdst_d;
            memtoreg_q <= memtoreg_d;
            loadtype_q <= loadtype_d;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q + {31'd0, valid_q & ~stall};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Self-checking bench for wb_stage_pipelined: behavioural model plus directed literal checks.
module tb_wb_stage_pipelined;

    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0]       IR = '0, PC_plus_4 = '0, Memory_Read_Data = '0, ALU_out = '0;
    logic              RegWrite = 1'b0;
    logic [1:0]        RegDst = '0, MemtoReg = '0;
    logic [2:0]        LoadType = '0;
    logic [NR*5-1:0]   rd_addr = '0;
    logic [NR*32-1:0]  rd_data;
    logic [31:0]       WriteBackData;
    logic [4:0]        WriteBackReg;
    logic              WriteBackEn, wb_valid;
    logic [31:0]       retire_count;

    always #5 clk = ~clk;

    wb_stage_pipelined #(.NUM_READ(NR), .LINK_REG(31), .ZERO_REG_HARD(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .IR(IR), .PC_plus_4(PC_plus_4), .Memory_Read_Data(Memory_Read_Data), .ALU_out(ALU_out),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .LoadType(LoadType),
        .rd_addr(rd_addr), .rd_data(rd_data), .WriteBackData(WriteBackData),
        .WriteBackReg(WriteBackReg), .WriteBackEn(WriteBackEn), .wb_valid(wb_valid),
        .retire_count(retire_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage holds, the architectural registers, retirements.
    logic        m_valid = 1'b0;
    logic [31:0] m_ir = '0, m_pc4 = '0, m_mrd = '0, m_alu = '0;
    logic        m_rw = 1'b0;
    logic [1:0]  m_rdst = '0, m_m2r = '0;
    logic [2:0]  m_lt = '0;
    logic [31:0] m_regs [32];
    int unsigned m_cnt = 0;

    function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [31:0] w,
                                               input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            3'b001:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b010:  return b;
            3'b011:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [4:0] m_dest();
        if (m_rdst == 2'b01) return m_ir[15:11];
        if (m_rdst == 2'b10) return 5'd31;
        return m_ir[20:16];
    endfunction

    function automatic logic [31:0] m_data();
        if (m_m2r == 2'b00) return m_alu;
        if (m_m2r == 2'b01) return load_value(m_lt, m_mrd, m_alu[1:0]);
        return m_pc4;
    endfunction

    function automatic logic m_en(input logic st);
        return m_valid && m_rw && !st && (m_dest() != 5'd0);
    endfunction

    function automatic logic [31:0] m_retire();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 1'b0; m_ir = '0; m_pc4 = '0; m_mrd = '0; m_alu = '0;
            m_rw = 1'b0; m_rdst = '0; m_m2r = '0; m_lt = '0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (m_en(stall)) m_regs[m_dest()] = m_data();
            if (m_valid && !stall) m_cnt = m_cnt + 1;
            if (!stall) begin
                if (flush) begin
                    m_valid = 1'b0;
                end else begin
                    m_valid = in_valid; m_ir = IR; m_pc4 = PC_plus_4; m_mrd = Memory_Read_Data;
                    m_alu = ALU_out; m_rw = RegWrite; m_rdst = RegDst; m_m2r = MemtoReg;
                    m_lt = LoadType;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]  a;
        logic [31:0] e;
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
        chk("wb_en", {31'd0, WriteBackEn}, {31'd0, m_en(stall)});
        chk("retire_count", retire_count, m_retire());
        if (m_valid) begin
            chk("wb_reg", {27'd0, WriteBackReg}, {27'd0, m_dest()});
            chk("wb_data", WriteBackData, m_data());
        end
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[5*k +: 5];
            if (a == 5'd0)                          e = '0;
            else if (m_en(stall) && a == m_dest())  e = m_data();
            else                                    e = m_regs[a];
            chk("rd_data", rd_data[32*k +: 32], e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ir, pc4, mrd, alu, input logic rw,
                          input logic [1:0] rdst, m2r, input logic [2:0] lt);
        in_valid = v; IR = ir; PC_plus_4 = pc4; Memory_Read_Data = mrd; ALU_out = alu;
        RegWrite = rw; RegDst = rdst; MemtoReg = m2r; LoadType = lt;
    endtask

    task automatic idle();
        set_in(1'b0, '0, '0, '0, '0, 1'b0, 2'b00, 2'b00, 3'b000);
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic load_case(input string name, input logic [2:0] lt, input logic [31:0] mrd,
                             input logic [31:0] alu, input logic [31:0] exp);
        set_in(1'b1, 32'h8C09_0000, '0, mrd, alu, 1'b1, 2'b00, 2'b01, lt);
        tick();
        idle();
        #1;
        chk(name, WriteBackData, exp);
        tick();
    endtask

    logic [31:0] c0;

    initial begin
        repeat (3) tick();
        chk("reset_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_en", {31'd0, WriteBackEn}, 32'd0);
        chk("reset_data", WriteBackData, 32'd0);
        chk("reset_reg", {27'd0, WriteBackReg}, 32'd0);
        chk("reset_retire", retire_count, 32'd0);
        reset = 1'b1;
        tick();

        // R-type rd=8 with bypass, then register read
        set_in(1'b1, 32'h012A_4020, '0, '0, 32'h55, 1'b1, 2'b01, 2'b00, 3'b000);
        rd_addr = {5'd8, 5'd8};
        tick();
        idle();
        #1;
        chk("rtype_reg", {27'd0, WriteBackReg}, 32'd8);
        chk("rtype_data", WriteBackData, 32'h55);
        chk("rtype_bypass", rd_data[31:0], 32'h55);
        tick();
        chk("rtype_regfile", rd_data[63:32], 32'h55);
        chk("model_reg8", m_regs[8], 32'h55);

        load_case("lb", 3'b001, 32'h1122_8344, 32'h0000_1001, 32'hFFFF_FF83);
        load_case("lbu", 3'b010, 32'h1122_8344, 32'h0000_1001, 32'h0000_0083);
        load_case("lh", 3'b011, 32'h1122_8344, 32'h0000_1002, 32'h0000_1122);
        load_case("lhu", 3'b100, 32'h8000_0000, 32'h0000_0002, 32'h0000_8000);

        // JAL to the link register, then a write aimed at register 0
        set_in(1'b1, 32'h0C00_0000, 32'h0040_0008, '0, '0, 1'b1, 2'b10, 2'b10, 3'b000);
        tick();
        idle();
        tick();
        rd_addr = {5'd0, 5'd31};
        #1;
        chk("jal_r31", rd_data[31:0], 32'h0040_0008);
        set_in(1'b1, 32'h0000_0020, '0, '0, 32'hDEAD, 1'b1, 2'b01, 2'b00, 3'b000);
        tick();
        idle();
        #1;
        chk("r0_no_en", {31'd0, WriteBackEn}, 32'd0);
        tick();
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("r0_reads_zero", rd_data[31:0], 32'd0);

        // three-cycle stall on a held write
        set_in(1'b1, 32'h0000_5020, '0, '0, 32'h1234, 1'b1, 2'b01, 2'b00, 3'b000);
        rd_addr = {5'd10, 5'd10};
        tick();
        idle();
        stall = 1'b1;
        c0 = retire_count;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_no_en", {31'd0, WriteBackEn}, 32'd0);
            chk("stall_no_write", rd_data[31:0], 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("release_en", {31'd0, WriteBackEn}, 32'd1);
        tick();
        chk("release_written", rd_data[31:0], 32'h1234);
        chk("release_once", {31'd0, WriteBackEn}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_plus1", retire_count, c0 + 32'd1);
`else
        chk("retire_tied0", retire_count, 32'd0);
`endif

        // flush kills incoming, held instruction commits
        set_in(1'b1, 32'h0000_5820, '0, '0, 32'h77, 1'b1, 2'b01, 2'b00, 3'b000);
        tick();
        set_in(1'b1, 32'h0000_6020, '0, '0, 32'h88, 1'b1, 2'b01, 2'b00, 3'b000);
        flush = 1'b1;
        rd_addr = {5'd12, 5'd11};
        #1;
        chk("flush_held_en", {31'd0, WriteBackEn}, 32'd1);
        tick();
        idle();
        #1;
        chk("flush_valid0", {31'd0, wb_valid}, 32'd0);
        chk("flush_r11", rd_data[31:0], 32'h77);
        chk("flush_r12", rd_data[63:32], 32'd0);

        // reset mid-stall drops the pending write
        set_in(1'b1, 32'h0000_6820, '0, '0, 32'hBEEF, 1'b1, 2'b01, 2'b00, 3'b000);
        rd_addr = {5'd13, 5'd13};
        tick();
        idle();
        stall = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mid_en", {31'd0, WriteBackEn}, 32'd0);
        chk("rst_mid_data", WriteBackData, 32'd0);
        chk("rst_mid_reg", {27'd0, WriteBackReg}, 32'd0);
        chk("rst_mid_retire", retire_count, 32'd0);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        tick();
        chk("rst_no_write", rd_data[31:0], 32'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ir;
            logic [4:0]  a0, a1;
            ir = $urandom;
            ir[20:16] = 5'($urandom_range(0, 7));
            ir[15:11] = 5'($urandom_range(0, 7));
            set_in(1'($urandom_range(0, 3) != 0), ir, $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            a0 = 5'($urandom_range(0, 8));
            a1 = 5'($urandom_range(0, 8));
            if (a0 == 5'd8) a0 = 5'd31;
            if (a1 == 5'd8) a1 = 5'd31;
            rd_addr = {a1, a0};
            tick();
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
